// File: rtl/kbd_pkg.sv
// ---------------------------------------------------------------------------
// kbd_pkg
// Shared definitions for the PS/2 scan code sequencer:
//   - kbd_state_t : prefix decoder state encoding
//   - byte constants for scan code set 2 prefixes, status and error bytes
//   - kbd_event_t : queued key event record {ext, brk, code[7:0]}
//   - helper functions that classify a received byte
// ---------------------------------------------------------------------------
package kbd_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_E0    = 3'd1,
        S_F0    = 3'd2,
        S_E0F0  = 3'd3,
        S_PAUSE = 3'd4
    } kbd_state_t;

    localparam logic [7:0] PFX_E0     = 8'hE0;
    localparam logic [7:0] PFX_F0     = 8'hF0;
    localparam logic [7:0] PFX_E1     = 8'hE1;
    localparam logic [7:0] ST_BAT     = 8'hAA;
    localparam logic [7:0] ST_ACK     = 8'hFA;
    localparam logic [7:0] ST_ECHO    = 8'hEE;
    localparam logic [7:0] ST_RESEND  = 8'hFE;
    localparam logic [7:0] ERR_00     = 8'h00;
    localparam logic [7:0] ERR_FF     = 8'hFF;
    localparam logic [7:0] PAUSE_CODE = 8'h77;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_event_t;

    // Keyboard housekeeping bytes that never form part of a key sequence
    function automatic logic is_status(input logic [7:0] b);
        return (b == ST_BAT) || (b == ST_ACK) || (b == ST_ECHO) || (b == ST_RESEND);
    endfunction

    // Keyboard buffer overrun / internal error indications
    function automatic logic is_error(input logic [7:0] b);
        return (b == ERR_00) || (b == ERR_FF);
    endfunction

endpackage

// File: rtl/kbd_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// kbd_scan_ctrl_if
// Bundles the receiver byte strobe, the event FIFO read port and the status
// flags of kbd_scan_ctrl.
//   master : environment side (drives keyboard_data/keyboard_rdy/event_pop)
//   slave  : kbd_scan_ctrl side (drives event_*, fifo_count, overflow, kbd_err)
// ---------------------------------------------------------------------------
interface kbd_scan_ctrl_if #(
    parameter int AW = 3
);
    logic [7:0]  keyboard_data;
    logic        keyboard_rdy;
    logic        event_valid;
    logic [7:0]  event_code;
    logic        event_ext;
    logic        event_break;
    logic        event_pop;
    logic [AW:0] fifo_count;
    logic        overflow;
    logic        kbd_err;

    modport master (
        output keyboard_data, keyboard_rdy, event_pop,
        input  event_valid, event_code, event_ext, event_break,
        input  fifo_count, overflow, kbd_err
    );

    modport slave (
        input  keyboard_data, keyboard_rdy, event_pop,
        output event_valid, event_code, event_ext, event_break,
        output fifo_count, overflow, kbd_err
    );
endinterface

// File: rtl/kbd_event_fifo.sv
// ---------------------------------------------------------------------------
// kbd_event_fifo
// DEPTH x 10-bit synchronous FIFO with first-word fall-through read.
//   clk, reset (sync, active-low)
//   push, push_data : write request and record
//   pop,  pop_data  : head acknowledge and head record (0 while empty)
//   count, full, empty : occupancy
// ---------------------------------------------------------------------------
module kbd_event_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [9:0]  push_data,
    input  logic        pop,
    output logic [9:0]  pop_data,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // accept a push when it is paired with a pop.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign pop_data = empty ? 10'd0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/kbd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// kbd_scan_ctrl
// Decodes scan code set 2 prefix sequences (E0, F0, E0 F0, E1 Pause) from the
// PS/2 receiver byte strobe into key events and queues them in a FIFO.
//   clk, reset (sync, active-low)
//   bus.keyboard_data / keyboard_rdy : received byte and its one-cycle strobe
//   bus.event_* / event_pop          : FWFT head of the event queue
//   bus.fifo_count                   : queue occupancy
//   bus.overflow / kbd_err           : sticky drop and keyboard-error flags
// ---------------------------------------------------------------------------
module kbd_scan_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic            clk,
    input  logic            reset,
    kbd_scan_ctrl_if.slave  bus
);
    import kbd_pkg::*;

    kbd_state_t state, state_n;
    logic [2:0] skip_cnt, skip_n;
    logic       push;
    kbd_event_t push_evt;
    kbd_event_t head_evt;
    logic       err_set;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow_q;
    logic       kbd_err_q;

    // Next-state decode; the push is decided in the strobe cycle so the event
    // lands in the FIFO on that same clock edge.
    always_comb begin
        state_n  = state;
        skip_n   = skip_cnt;
        push     = 1'b0;
        push_evt = '0;
        err_set  = 1'b0;
        if (bus.keyboard_rdy) begin
            case (state)
                S_IDLE: begin
                    if (bus.keyboard_data == PFX_E0) begin
                        state_n = S_E0;
                    end else if (bus.keyboard_data == PFX_F0) begin
                        state_n = S_F0;
                    end else if (bus.keyboard_data == PFX_E1) begin
                        state_n = S_PAUSE;
                        skip_n  = PAUSE_SKIP;
                    end else if (is_status(bus.keyboard_data)) begin
                        state_n = S_IDLE;
                    end else if (is_error(bus.keyboard_data)) begin
                        err_set = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b0, brk: 1'b0, code: bus.keyboard_data};
                    end
                end
                S_E0: begin
                    if (bus.keyboard_data == PFX_F0) begin
                        state_n = S_E0F0;
                    end else if (bus.keyboard_data == PFX_E0) begin
                        state_n = S_E0;
                    end else if (is_error(bus.keyboard_data)) begin
                        err_set = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b1, brk: 1'b0, code: bus.keyboard_data};
                        state_n  = S_IDLE;
                    end
                end
                S_F0, S_E0F0: begin
                    if (is_error(bus.keyboard_data)) begin
                        err_set = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_evt = '{ext: (state == S_E0F0), brk: 1'b1,
                                     code: bus.keyboard_data};
                    end
                    state_n = S_IDLE;
                end
                S_PAUSE: begin
                    // Pause bytes are skipped blindly; the last one emits the key
                    if (skip_cnt == 3'd1) begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b1, brk: 1'b0, code: PAUSE_CODE};
                        skip_n   = 3'd0;
                        state_n  = S_IDLE;
                    end else begin
                        skip_n = skip_cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            skip_cnt   <= 3'd0;
            kbd_err_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state     <= state_n;
            skip_cnt  <= skip_n;
            kbd_err_q <= kbd_err_q | err_set;
            if (push && fifo_full && !bus.event_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    kbd_event_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (bus.event_pop),
        .pop_data  (head_evt),
        .count     (bus.fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.event_valid = !fifo_empty;
    assign bus.event_code  = head_evt.code;
    assign bus.event_ext   = head_evt.ext;
    assign bus.event_break = head_evt.brk;
    assign bus.overflow    = overflow_q;
    assign bus.kbd_err     = kbd_err_q;
endmodule

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
- Sequencer behind the PS/2 keyboard receiver. It consumes the receiver's byte/ready pulses and decodes scan code set 2 prefix sequences (E0, F0, E1 Pause).
- Each complete sequence becomes one key event (code, extended flag, break flag), queued in a small FIFO.
- Consumers (game logic or the CPU port) drain the FIFO with a pop handshake. The block also discards keyboard status bytes and flags protocol errors.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- AW, 3, FIFO address width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low. reset==0 at a rising edge of clk resets the block.
- keyboard_data  in  8  byte from the receiver; valid only while keyboard_rdy==1.
- keyboard_rdy  in  1  one-cycle strobe from the receiver: a new byte is present.
- event_valid  out  1  FIFO non-empty; head entry is presented on event_*.
- event_code  out  8  head entry: final scan byte (8'h77 for Pause).
- event_ext  out  1  head entry: E0-prefixed key (1 for Pause).
- event_break  out  1  head entry: key release.
- event_pop  in  1  consumer acknowledges the head entry this cycle.
- fifo_count  out  AW+1  number of valid entries, 0..DEPTH.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- kbd_err  out  1  sticky: keyboard reported an error byte (8'h00 or 8'hFF).

Behaviour:
- Reset values: event_valid=0, fifo_count=0, overflow=0, kbd_err=0, FSM=IDLE, pointers=0. event_code, event_ext and event_break are 0.
- Reset mid-sequence discards any partial prefix and all queued entries.
- Bytes are sampled only in cycles with keyboard_rdy==1. Other cycles leave the FSM unchanged.
- FSM states: IDLE, E0, F0, E0F0, PAUSE.
- IDLE:
  - 8'hE0 -> E0.
  - 8'hF0 -> F0.
  - 8'hE1 -> PAUSE, with skip counter=7.
  - 8'hAA, 8'hFA, 8'hEE, 8'hFE -> discarded, stay in IDLE.
  - 8'h00 or 8'hFF -> set kbd_err, stay in IDLE, no event.
  - Any other byte b -> push {b, ext=0, brk=0}, stay in IDLE.
- E0:
  - 8'hF0 -> E0F0.
  - 8'hE0 -> stay in E0.
  - 8'h00/8'hFF -> set kbd_err, go to IDLE.
  - Other byte b -> push {b, ext=1, brk=0}, go to IDLE.
  - 8'h12 after E0 (fake shift) is a normal event; no special case.
- F0: byte b -> push {b, 0, 1}, go to IDLE. 8'h00/8'hFF set kbd_err instead of pushing.
- E0F0: byte b -> push {b, 1, 1}, go to IDLE. Same error rule as F0.
- PAUSE:
  - Each byte decrements the skip counter; contents are ignored.
  - When the counter reaches 0 after the 7th byte, push {8'h77, 1, 0} and go to IDLE.
  - Exactly one event is produced per E1 sequence; no break event is generated for Pause.
- Latency: a push decided in the keyboard_rdy cycle is written at that cycle's clock edge. event_valid and the entry appear the next cycle.
- FIFO:
  - Read is first-word fall-through; event_* always reflect the head entry.
  - A pop while empty is ignored.
  - A push while full with no pop is dropped; overflow is set, and count and contents are unchanged.
  - A push and a pop in the same cycle are both accepted, including when the FIFO is full; count is unchanged.
  - Pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH and never underflows.
- overflow and kbd_err clear only on reset.

Decomposition:
- Shared package kbd_pkg:
  - FSM state encoding.
  - Byte constants: PFX_E0=8'hE0, PFX_F0=8'hF0, PFX_E1=8'hE1, ST_BAT=8'hAA, ST_ACK=8'hFA, ST_ECHO=8'hEE, ST_RESEND=8'hFE, ERR_00=8'h00, ERR_FF=8'hFF, PAUSE_CODE=8'h77, PAUSE_SKIP=7.
  - Event record layout: {ext, brk, code[7:0]}.
- One sub-module, kbd_event_fifo: DEPTH x 10-bit synchronous FIFO with push, pop, count, full and empty, using the same clk and active-low synchronous reset.

Test Plan:
- Bytes 1C; F0 1C -> two events in order: {1C,0,0} then {1C,0,1}. event_valid rises 1 cycle after each final strobe.
- Bytes E0 75; E0 F0 75 -> events {75,1,0} and {75,1,1}. fifo_count goes 1 then 2 with no pops.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {77,1,0}. Then byte 1C -> {1C,0,0}, confirming return to IDLE.
- Bytes AA, FA, EE, FE -> no events, fifo_count=0. Byte FF -> kbd_err=1, no event.
- With DEPTH=8, nine make codes 01..09 and no pops -> fifo_count=8, overflow=1, entries 01..08 retained. Next, push 0A with a simultaneous pop -> 01 removed, 0A accepted, count stays 8.
- Byte E0, then reset=0 for one cycle, then byte 1C -> single event {1C,0,0}, overflow=0, kbd_err=0.
